// File: rtl/mymul_pkg.sv
// Shared definitions for the mymul Avalon-MM driver: register map, FSM states, bus command payload.
package mymul_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ADDR_W    = 3;
    localparam int unsigned RES_W     = 64;
    localparam int unsigned LAT_CNT_W = 2;

    localparam logic [ADDR_W-1:0] MYMUL_A   = 3'd0;
    localparam logic [ADDR_W-1:0] MYMUL_B   = 3'd1;
    localparam logic [ADDR_W-1:0] MYMUL_LO  = 3'd2;
    localparam logic [ADDR_W-1:0] MYMUL_HI  = 3'd3;
    localparam logic [ADDR_W-1:0] MYMUL_CTL = 3'd4;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_A,
        ST_WR_B,
        ST_WR_C0,
        ST_WR_C1,
        ST_SETTLE,
        ST_RD_LO,
        ST_LAT_LO,
        ST_RD_HI,
        ST_LAT_HI
    } mymul_drv_state_t;

    typedef struct packed {
        logic              read;
        logic              write;
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] writedata;
    } avm_cmd_t;

endpackage

// File: rtl/mymul_driver.sv
// Avalon-MM master that runs the full mymul register sequence for one start pulse
// and returns the 64-bit product with a single-cycle done.
module mymul_driver
    import mymul_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [RES_W-1:0]  result,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest
);

    localparam bit                   HAS_LAT  = (READ_LATENCY != 0);
    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(READ_LATENCY - 1);

    mymul_drv_state_t     state_q, state_d;
    logic [DATA_W-1:0]    a_q, a_d;
    logic [DATA_W-1:0]    b_q, b_d;
    logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
    avm_cmd_t             cmd_q, cmd_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [RES_W-1:0]     result_q, result_d;

    // State and registered bus/status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            cmd_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            cmd_q    <= cmd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    // Next-state, result capture and next bus command.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        result_d = result_q;
        cmd_d    = '{read: 1'b0, write: 1'b0, address: cmd_q.address, writedata: cmd_q.writedata};

        unique case (state_q)
            // The done cycle is still part of the run, so a start there is dropped.
            ST_IDLE: begin
                if (start && !done_q) begin
                    a_d     = a;
                    b_d     = b;
                    state_d = ST_WR_A;
                end
            end
            ST_WR_A:   if (!avm_waitrequest) state_d = ST_WR_B;
            ST_WR_B:   if (!avm_waitrequest) state_d = ST_WR_C0;
            ST_WR_C0:  if (!avm_waitrequest) state_d = ST_WR_C1;
            ST_WR_C1:  if (!avm_waitrequest) state_d = ST_SETTLE;
            ST_SETTLE: state_d = ST_RD_LO;
            ST_RD_LO: begin
                if (!avm_waitrequest) begin
                    if (HAS_LAT) begin
                        cnt_d   = LAT_LOAD;
                        state_d = ST_LAT_LO;
                    end else begin
                        result_d[31:0] = avm_readdata;
                        state_d        = ST_RD_HI;
                    end
                end
            end
            ST_LAT_LO: begin
                if (cnt_q == '0) begin
                    result_d[31:0] = avm_readdata;
                    state_d        = ST_RD_HI;
                end else begin
                    cnt_d = cnt_q - LAT_CNT_W'(1);
                end
            end
            ST_RD_HI: begin
                if (!avm_waitrequest) begin
                    if (HAS_LAT) begin
                        cnt_d   = LAT_LOAD;
                        state_d = ST_LAT_HI;
                    end else begin
                        result_d[63:32] = avm_readdata;
                        done_d          = 1'b1;
                        state_d         = ST_IDLE;
                    end
                end
            end
            ST_LAT_HI: begin
                if (cnt_q == '0) begin
                    result_d[63:32] = avm_readdata;
                    done_d          = 1'b1;
                    state_d         = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - LAT_CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Strobes are registered, so they are decoded from the state being entered.
        unique case (state_d)
            ST_WR_A:  cmd_d = '{read: 1'b0, write: 1'b1, address: MYMUL_A,   writedata: a_d};
            ST_WR_B:  cmd_d = '{read: 1'b0, write: 1'b1, address: MYMUL_B,   writedata: b_d};
            ST_WR_C0: cmd_d = '{read: 1'b0, write: 1'b1, address: MYMUL_CTL, writedata: 32'd0};
            ST_WR_C1: cmd_d = '{read: 1'b0, write: 1'b1, address: MYMUL_CTL, writedata: 32'd1};
            ST_RD_LO: cmd_d = '{read: 1'b1, write: 1'b0, address: MYMUL_LO,  writedata: cmd_q.writedata};
            ST_RD_HI: cmd_d = '{read: 1'b1, write: 1'b0, address: MYMUL_HI,  writedata: cmd_q.writedata};
            default:  ;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign result        = result_q;
    assign avm_address   = cmd_q.address;
    assign avm_read      = cmd_q.read;
    assign avm_write     = cmd_q.write;
    assign avm_writedata = cmd_q.writedata;

endmodule

// File: tb/tb_mymul_driver.sv
// Directed bench for mymul_driver: two instances (read latency 0 and 2), each on a behavioural mymul slave.
module tb_mymul_driver;

    logic clk = 1'b0;
    logic reset;
    logic s_rst;
    logic [31:0] a_s, b_s;

    logic [1:0]       m_start;
    logic [1:0]       m_busy, m_done, m_rd, m_wr, m_wait;
    logic [1:0][63:0] m_res;
    logic [1:0][2:0]  m_addr;
    logic [1:0][31:0] m_wd, m_rdata;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int base;
    int n;

    always #5 clk = ~clk;

    mymul_driver #(.READ_LATENCY(0)) dut0 (
        .clk(clk), .reset(reset), .start(m_start[0]), .a(a_s), .b(b_s),
        .busy(m_busy[0]), .done(m_done[0]), .result(m_res[0]),
        .avm_address(m_addr[0]), .avm_read(m_rd[0]), .avm_write(m_wr[0]),
        .avm_writedata(m_wd[0]), .avm_readdata(m_rdata[0]), .avm_waitrequest(m_wait[0])
    );

    mymul_driver #(.READ_LATENCY(2)) dut2 (
        .clk(clk), .reset(reset), .start(m_start[1]), .a(a_s), .b(b_s),
        .busy(m_busy[1]), .done(m_done[1]), .result(m_res[1]),
        .avm_address(m_addr[1]), .avm_read(m_rd[1]), .avm_write(m_wr[1]),
        .avm_writedata(m_wd[1]), .avm_readdata(m_rdata[1]), .avm_waitrequest(m_wait[1])
    );

    // Slave model: product registered one cycle after a 0->1 edge of the control bit.
    logic [31:0] sl_a [2];
    logic [31:0] sl_b [2];
    logic        sl_c [2];
    logic        sl_cp[2];
    logic [63:0] sl_p [2];
    logic [31:0] comb_rd[2];
    logic [31:0] pipe1, pipe2;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (s_rst) begin
                sl_a[i]  <= '0;
                sl_b[i]  <= '0;
                sl_c[i]  <= 1'b0;
                sl_cp[i] <= 1'b0;
                sl_p[i]  <= '0;
            end else begin
                sl_cp[i] <= sl_c[i];
                if (m_wr[i] && !m_wait[i]) begin
                    case (m_addr[i])
                        3'd0:    sl_a[i] <= m_wd[i];
                        3'd1:    sl_b[i] <= m_wd[i];
                        3'd4:    sl_c[i] <= m_wd[i][0];
                        default: ;
                    endcase
                end
                if (sl_c[i] && !sl_cp[i]) sl_p[i] <= {32'd0, sl_a[i]} * {32'd0, sl_b[i]};
            end
        end
        pipe1 <= comb_rd[1];
        pipe2 <= pipe1;
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            comb_rd[i] = '0;
            case (m_addr[i])
                3'd0:    comb_rd[i] = sl_a[i];
                3'd1:    comb_rd[i] = sl_b[i];
                3'd2:    comb_rd[i] = sl_p[i][31:0];
                3'd3:    comb_rd[i] = sl_p[i][63:32];
                default: comb_rd[i] = {31'd0, sl_c[i]};
            endcase
        end
    end

    assign m_rdata[0] = comb_rd[0];
    assign m_rdata[1] = pipe2;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // {read, write, address, writedata} of instance i.
    task automatic chk_bus(input string tag, input int i, input logic rd, input logic wr,
                           input logic [2:0] ad, input logic [31:0] wd);
        chk(tag, {27'd0, m_rd[i], m_wr[i], m_addr[i], m_wd[i]}, {27'd0, rd, wr, ad, wd});
    endtask

    task automatic run(input int i, input logic [31:0] av, input logic [31:0] bv, output int cnt);
        a_s = av;
        b_s = bv;
        m_start[i] = 1'b1;
        tick();
        m_start[i] = 1'b0;
        cnt = 0;
        while (cnt < 40) begin
            tick();
            cnt++;
            if (m_done[i]) break;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        s_rst   = 1'b1;
        m_start = '0;
        m_wait  = '0;
        a_s     = '0;
        b_s     = '0;
        tick();
        tick();
        chk("rst_status0", {m_busy[0], m_done[0], m_res[0][61:0]}, 64'd0);
        chk_bus("rst_bus0", 0, 1'b0, 1'b0, 3'd0, 32'd0);
        chk("rst_status2", {m_busy[1], m_done[1], m_rd[1], m_wr[1], m_res[1][59:0]}, 64'd0);
        reset = 1'b0;
        s_rst = 1'b0;
        tick();

        // 1: 3 x 5, bus sequence cycle by cycle
        a_s = 32'd3;
        b_s = 32'd5;
        m_start[0] = 1'b1;
        tick();
        m_start[0] = 1'b0;
        base = cyc;
        chk("t1_busy", 64'(m_busy[0]), 64'd1);
        chk_bus("t1_wr_a", 0, 1'b0, 1'b1, 3'd0, 32'd3);
        tick();
        chk_bus("t1_wr_b", 0, 1'b0, 1'b1, 3'd1, 32'd5);
        tick();
        chk_bus("t1_wr_c0", 0, 1'b0, 1'b1, 3'd4, 32'd0);
        tick();
        chk_bus("t1_wr_c1", 0, 1'b0, 1'b1, 3'd4, 32'd1);
        tick();
        chk("t1_settle", {62'd0, m_rd[0], m_wr[0]}, 64'd0);
        tick();
        chk("t1_rd_lo", {59'd0, m_rd[0], m_wr[0], m_addr[0]}, {59'd0, 1'b1, 1'b0, 3'd2});
        tick();
        chk("t1_rd_hi", {59'd0, m_rd[0], m_wr[0], m_addr[0]}, {59'd0, 1'b1, 1'b0, 3'd3});
        tick();
        chk("t1_done", {62'd0, m_done[0], m_busy[0]}, 64'd2);
        chk("t1_lat", 64'(cyc - base), 64'd7);
        chk("t1_result", m_res[0], 64'h0000_0000_0000_000F);
        tick();
        chk("t1_done_pulse", 64'(m_done[0]), 64'd0);
        chk("t1_result_hold", m_res[0], 64'h0000_0000_0000_000F);

        // 2: operand extremes
        run(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
        chk("t2_max_lat", 64'(n), 64'd7);
        chk("t2_max", m_res[0], 64'hFFFF_FFFE_0000_0001);
        tick();
        run(0, 32'd0, 32'h1234, n);
        chk("t2_zero", m_res[0], 64'd0);
        tick();

        // 3: waitrequest 3 cycles in WR_B, 2 cycles in RD_HI
        a_s = 32'h10;
        b_s = 32'h20;
        m_start[0] = 1'b1;
        tick();
        m_start[0] = 1'b0;
        base = cyc;
        chk_bus("t3_wr_a", 0, 1'b0, 1'b1, 3'd0, 32'h10);
        tick();
        m_wait[0] = 1'b1;
        chk_bus("t3_wr_b_s0", 0, 1'b0, 1'b1, 3'd1, 32'h20);
        tick();
        chk_bus("t3_wr_b_s1", 0, 1'b0, 1'b1, 3'd1, 32'h20);
        tick();
        chk_bus("t3_wr_b_s2", 0, 1'b0, 1'b1, 3'd1, 32'h20);
        tick();
        m_wait[0] = 1'b0;
        chk_bus("t3_wr_b_go", 0, 1'b0, 1'b1, 3'd1, 32'h20);
        tick();
        chk_bus("t3_wr_c0", 0, 1'b0, 1'b1, 3'd4, 32'd0);
        tick();
        tick();
        tick();
        chk("t3_rd_lo", {59'd0, m_rd[0], m_wr[0], m_addr[0]}, {59'd0, 1'b1, 1'b0, 3'd2});
        tick();
        m_wait[0] = 1'b1;
        chk("t3_rd_hi_s0", {59'd0, m_rd[0], m_wr[0], m_addr[0]}, {59'd0, 1'b1, 1'b0, 3'd3});
        tick();
        chk("t3_rd_hi_s1", {59'd0, m_rd[0], m_wr[0], m_addr[0], m_done[0]}, {58'd0, 1'b1, 1'b0, 3'd3, 1'b0});
        tick();
        m_wait[0] = 1'b0;
        chk("t3_rd_hi_go", {59'd0, m_rd[0], m_wr[0], m_addr[0]}, {59'd0, 1'b1, 1'b0, 3'd3});
        tick();
        chk("t3_done", 64'(m_done[0]), 64'd1);
        chk("t3_lat", 64'(cyc - base), 64'd12);
        chk("t3_result", m_res[0], 64'h200);
        tick();

        // 4: start while busy and start coincident with done are both dropped
        a_s = 32'd3;
        b_s = 32'd5;
        m_start[0] = 1'b1;
        tick();
        m_start[0] = 1'b0;
        base = cyc;
        tick();
        tick();
        a_s = 32'd9;
        b_s = 32'd9;
        m_start[0] = 1'b1;
        tick();
        m_start[0] = 1'b0;
        a_s = 32'd3;
        b_s = 32'd5;
        n = 0;
        while (n < 40 && !m_done[0]) begin
            tick();
            n++;
        end
        chk("t4_lat", 64'(cyc - base), 64'd7);
        chk("t4_result", m_res[0], 64'd15);
        a_s = 32'd9;
        b_s = 32'd9;
        m_start[0] = 1'b1;
        tick();
        m_start[0] = 1'b0;
        chk("t4_after_done", {61'd0, m_busy[0], m_rd[0], m_wr[0]}, 64'd0);
        tick();
        chk("t4_still_idle", {62'd0, m_busy[0], m_done[0]}, 64'd0);
        chk("t4_result_hold", m_res[0], 64'd15);

        // 5: reset right after WR_C1 leaves the slave control bit at 1
        a_s = 32'd4;
        b_s = 32'd4;
        m_start[0] = 1'b1;
        tick();
        m_start[0] = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_reset_status", {m_busy[0], m_done[0], m_res[0][61:0]}, 64'd0);
        chk_bus("t5_reset_bus", 0, 1'b0, 1'b0, 3'd0, 32'd0);
        tick();
        chk("t5_no_done", 64'(m_done[0]), 64'd0);
        run(0, 32'd7, 32'd6, n);
        chk("t5_lat", 64'(n), 64'd7);
        chk("t5_result", m_res[0], 64'd42);
        tick();

        // 6: read latency 2 against a pipelined slave
        run(1, 32'h0001_0000, 32'h0001_0000, n);
        chk("t6_lat", 64'(n), 64'd11);
        chk("t6_result", m_res[1], 64'h0000_0001_0000_0000);
        tick();
        run(1, 32'd3, 32'd5, n);
        chk("t6_small", m_res[1], 64'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
